dmem_access_ctrl: RTL and testbench

- Memory-stage requester for the data memory: accepts one load/store request from the pipeline memory stage, range-checks it, drives the data memory's address/enable/data port, and returns m_valM-style read data plus an error flag.
- Initiator side of the data-memory interface. Replaces direct combinational strobing with a registered, multi-cycle, handshaked access.
- Stalls the pipeline while an access is in flight.

---
 rtl/dmem_access_ctrl_if.sv | 47 ++++
 rtl/dmem_access_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_if.sv
// Request/response and data-memory bundles for dmem_access_ctrl.
// master drives the request (pipeline) or the memory strobes (controller).
interface dmem_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rd;
  logic        req_wr;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_err;
  logic        m_stall;

  modport master (
    output req_valid, req_rd, req_wr,
    output req_addr, req_wdata,
    input  req_ready, resp_valid,
    input  resp_data, resp_err, m_stall
  );

  modport slave (
    input  req_valid, req_rd, req_wr,
    input  req_addr, req_wdata,
    output req_ready, resp_valid,
    output resp_data, resp_err, m_stall
  );
endinterface

interface dmem_bus_if;
  logic [63:0] dm_Add;
  logic        dm_wEn;
  logic        dm_rEn;
  logic [63:0] dm_wdata;
  logic [63:0] dm_rdata;
  logic        dm_err;

  modport master (
    output dm_Add, dm_wEn, dm_rEn, dm_wdata,
    input  dm_rdata, dm_err
  );

  modport slave (
    input  dm_Add, dm_wEn, dm_rEn, dm_wdata,
    output dm_rdata, dm_err
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Registered, handshaked data-memory requester for the memory stage.
// Optional store-to-load forwarding buffer: define DMEM_FWD_EN.
module dmem_access_ctrl #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned ACC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  dmem_req_if.slave  req,
  dmem_bus_if.master dm
);

  localparam int unsigned CW =
    (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(ACC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [63:0]   data_q, data_d;
  logic [63:0]   add_q, add_d;
  logic [63:0]   wdat_q, wdat_d;
  logic          wen_q, wen_d;
  logic          ren_q, ren_d;
  logic          bad_req;
  logic          last;

`ifdef DMEM_FWD_EN
  logic          sb_vld_q, sb_vld_d;
  logic [63:0]   sb_add_q, sb_add_d;
  logic [63:0]   sb_dat_q, sb_dat_d;
  logic          hit;
`endif

  // Reject malformed or out-of-range requests.
  always_comb begin
    bad_req = (req.req_rd == req.req_wr) ||
              (req.req_addr >= 64'(MEM_WORDS));
  end

`ifdef DMEM_FWD_EN
  // Load matching the last good store.
  always_comb begin
    hit = sb_vld_q && req.req_rd &&
          (req.req_addr == sb_add_q);
  end
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    data_d  = data_q;
    add_d   = add_q;
    wdat_d  = wdat_q;
    wen_d   = wen_q;
    ren_d   = ren_q;
    last    = (cnt_q == CNT_LAST);
`ifdef DMEM_FWD_EN
    sb_vld_d = sb_vld_q;
    sb_add_d = sb_add_q;
    sb_dat_d = sb_dat_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          err_d  = 1'b0;
          data_d = 64'h0;
          if (bad_req) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
`ifdef DMEM_FWD_EN
          else if (hit) begin
            data_d  = sb_dat_q;
            state_d = RESP;
          end
`endif
          else begin
            state_d = ACCESS;
            cnt_d   = '0;
            add_d   = req.req_addr;
            wdat_d  = req.req_wdata;
            wen_d   = req.req_wr;
            ren_d   = req.req_rd;
          end
        end
      end
      ACCESS: begin
        if (last) begin
          state_d = RESP;
          wen_d   = 1'b0;
          ren_d   = 1'b0;
          err_d   = err_q | dm.dm_err;
          data_d  = (ren_q && !dm.dm_err) ?
                    dm.dm_rdata : 64'h0;
`ifdef DMEM_FWD_EN
          if (wen_q && !dm.dm_err) begin
            sb_vld_d = 1'b1;
            sb_add_d = add_q;
            sb_dat_d = wdat_q;
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset kills strobes at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= 64'h0;
      add_q   <= 64'h0;
      wdat_q  <= 64'h0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
`ifdef DMEM_FWD_EN
      sb_vld_q <= 1'b0;
      sb_add_q <= 64'h0;
      sb_dat_q <= 64'h0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      data_q  <= data_d;
      add_q   <= add_d;
      wdat_q  <= wdat_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
`ifdef DMEM_FWD_EN
      sb_vld_q <= sb_vld_d;
      sb_add_q <= sb_add_d;
      sb_dat_q <= sb_dat_d;
`endif
    end
  end

  // Handshake outputs decoded from state; response gated to RESP.
  always_comb begin
    req.req_ready  = (state_q == IDLE);
    req.m_stall    = (state_q != IDLE);
    req.resp_valid = (state_q == RESP);
    req.resp_data  = (state_q == RESP) ?
                     data_q : 64'h0;
    req.resp_err   = (state_q == RESP) && err_q;
    dm.dm_Add      = add_q;
    dm.dm_wdata    = wdat_q;
    dm.dm_wEn      = wen_q;
    dm.dm_rEn      = ren_q;
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized self-checking bench for dmem_access_ctrl.
// Transaction-level model predicts per-cycle handshake and strobes.
module tb_dmem_access_ctrl;

  localparam int ACC   = 1;
  localparam int WORDS = 1024;
  localparam logic [63:0] ERR_ADDR = 64'd10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst3 = 1'b1;
  always #5 clk = ~clk;

  dmem_req_if rq ();
  dmem_bus_if bu ();
  dmem_req_if rq3 ();
  dmem_bus_if bu3 ();

  dmem_access_ctrl #(
    .MEM_WORDS (WORDS),
    .ACC_CYCLES(ACC)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .req(rq),
    .dm (bu)
  );

  dmem_access_ctrl #(
    .MEM_WORDS (WORDS),
    .ACC_CYCLES(3)
  ) u_dut3 (
    .clk(clk),
    .rst(rst3),
    .req(rq3),
    .dm (bu3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chkw(input string nm,
                      input logic [63:0] got,
                      input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s got=%h exp=%h t=%0t",
                 nm, got, exp, $time);
    end
  endtask

  task automatic chk1(input string nm,
                      input logic got,
                      input logic exp);
    chkw(nm, {63'h0, got}, {63'h0, exp});
  endtask

  function automatic logic [63:0] init_word(input int i);
    return 64'(i) * 64'h9E37_79B9_7F4A_7C15;
  endfunction

  // Memory device seen by the main DUT.
  logic [63:0] mem [0:WORDS-1];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++)
        mem[i] <= init_word(i);
    end else if (bu.dm_wEn && bu.dm_Add < 64'(WORDS)) begin
      mem[bu.dm_Add[9:0]] <= bu.dm_wdata;
    end
  end
  assign bu.dm_rdata =
    (bu.dm_rEn && bu.dm_Add < 64'(WORDS)) ?
    mem[bu.dm_Add[9:0]] : 64'hA5A5_5A5A_A5A5_5A5A;
  assign bu.dm_err =
    (bu.dm_rEn || bu.dm_wEn) && (bu.dm_Add == ERR_ADDR);

  assign bu3.dm_rdata = 64'h0;
  assign bu3.dm_err   = 1'b0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state (transaction level).
  logic [63:0] ref_mem [0:WORDS-1];
  logic        sb_v = 1'b0;
  logic [63:0] sb_a = 64'h0;
  logic [63:0] sb_d = 64'h0;
  bit          have_txn = 1'b0;
  int          t_a = 0;
  int          t_lat = 0;
  bit          t_acc = 1'b0;
  logic        t_rd = 1'b0;
  logic        t_wr = 1'b0;
  logic [63:0] t_data = 64'h0;
  logic        t_err = 1'b0;
  logic [63:0] exp_add = 64'h0;
  logic [63:0] exp_wd = 64'h0;

  // Observations from the compare process.
  int          n_resp = 0;
  int          n_wen = 0;
  int          n_ren = 0;
  int          n_stall = 0;
  int          got_cyc = 0;
  logic [63:0] got_data = 64'h0;
  logic        got_err = 1'b0;
  logic [63:0] last_wadd = 64'h0;

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin : cmp
    logic busy, strobe, rv;
    busy   = have_txn && (cyc >= t_a) &&
             (cyc <= t_a + t_lat);
    strobe = have_txn && t_acc && (cyc >= t_a) &&
             (cyc < t_a + ACC);
    rv     = have_txn && (cyc == t_a + t_lat);
    chk1("req_ready", rq.req_ready, !busy);
    chk1("m_stall", rq.m_stall, busy);
    chk1("resp_valid", rq.resp_valid, rv);
    chk1("dm_rEn", bu.dm_rEn, strobe && t_rd);
    chk1("dm_wEn", bu.dm_wEn, strobe && t_wr);
    chk1("strobe_excl", bu.dm_rEn && bu.dm_wEn, 1'b0);
    chkw("dm_Add", bu.dm_Add, exp_add);
    chkw("dm_wdata", bu.dm_wdata, exp_wd);
    if (rv) begin
      chkw("resp_data", rq.resp_data, t_data);
      chk1("resp_err", rq.resp_err, t_err);
    end
    if (rq.resp_valid === 1'b1) begin
      n_resp++;
      got_cyc  = cyc;
      got_data = rq.resp_data;
      got_err  = rq.resp_err;
    end
    if (bu.dm_wEn === 1'b1) begin
      n_wen++;
      last_wadd = bu.dm_Add;
    end
    if (bu.dm_rEn === 1'b1) n_ren++;
    if (rq.m_stall === 1'b1) n_stall++;
  end

  int r_lat, r_wen, r_ren, r_stall;

  task automatic issue(input logic rd, input logic wr,
                       input logic [63:0] addr,
                       input logic [63:0] wd,
                       input int gap);
    int n, r0, w0, e0, s0;
    logic legal, hit;
    repeat (gap) @(negedge clk);
    #1;
    rq.req_valid = 1'b1;
    rq.req_rd    = rd;
    rq.req_wr    = wr;
    rq.req_addr  = addr;
    rq.req_wdata = wd;
    n = 0;
    while (rq.req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk1("accept_ready", rq.req_ready, 1'b1);
    @(posedge clk);
    #1;
    rq.req_valid = 1'b0;
    legal = (rd != wr) && (addr < 64'(WORDS));
    hit = 1'b0;
`ifdef DMEM_FWD_EN
    hit = legal && rd && sb_v && (addr == sb_a);
`endif
    t_a  = cyc;
    t_rd = rd;
    t_wr = wr;
    if (!legal) begin
      t_lat = 0; t_acc = 1'b0;
      t_data = 64'h0; t_err = 1'b1;
    end else if (hit) begin
      t_lat = 0; t_acc = 1'b0;
      t_data = sb_d; t_err = 1'b0;
    end else begin
      t_lat = ACC; t_acc = 1'b1;
      t_err = (addr == ERR_ADDR);
      t_data = (rd && !t_err) ?
               ref_mem[addr[9:0]] : 64'h0;
      exp_add = addr;
      exp_wd  = wd;
      if (wr) begin
        ref_mem[addr[9:0]] = wd;
        if (!t_err) begin
          sb_v = 1'b1; sb_a = addr; sb_d = wd;
        end
      end
    end
    have_txn = 1'b1;
    r0 = n_resp; w0 = n_wen; e0 = n_ren; s0 = n_stall;
    n = 0;
    while (n_resp == r0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk1("resp_seen", n_resp != r0, 1'b1);
    r_lat   = got_cyc - t_a + 1;
    r_wen   = n_wen - w0;
    r_ren   = n_ren - e0;
    r_stall = n_stall - s0;
  endtask

  bit u3_pulse = 1'b0;
  bit u3_watch = 1'b0;
  always @(negedge clk)
    if (u3_watch && rq3.resp_valid === 1'b1) u3_pulse = 1'b1;

  int a1;

  initial begin
    rq.req_valid = 1'b0; rq.req_rd = 1'b0;
    rq.req_wr = 1'b0; rq.req_addr = 64'h0;
    rq.req_wdata = 64'h0;
    rq3.req_valid = 1'b0; rq3.req_rd = 1'b0;
    rq3.req_wr = 1'b0; rq3.req_addr = 64'h0;
    rq3.req_wdata = 64'h0;
    for (int i = 0; i < WORDS; i++)
      ref_mem[i] = init_word(i);
    #2;
    chk1("rst_ready", rq.req_ready, 1'b1);
    chk1("rst_stall", rq.m_stall, 1'b0);
    chk1("rst_resp_valid", rq.resp_valid, 1'b0);
    chkw("rst_resp_data", rq.resp_data, 64'h0);
    chk1("rst_resp_err", rq.resp_err, 1'b0);
    chk1("rst_wEn", bu.dm_wEn, 1'b0);
    chk1("rst_rEn", bu.dm_rEn, 1'b0);
    chkw("rst_dm_Add", bu.dm_Add, 64'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rst3 = 1'b0;

    issue(1'b0, 1'b1, 64'd5, 64'hDEAD_BEEF, 1);
    chkw("st_lat", 64'(r_lat), 64'd2);
    chk1("st_err", got_err, 1'b0);
    chkw("st_data", got_data, 64'h0);
    chkw("st_wen_cycles", 64'(r_wen), 64'd1);
    chkw("st_wadd", last_wadd, 64'd5);
    chkw("st_ren_cycles", 64'(r_ren), 64'd0);

    issue(1'b1, 1'b0, 64'd5, 64'h0, 1);
    chkw("ld_data", got_data, 64'hDEAD_BEEF);
    chk1("ld_err", got_err, 1'b0);
`ifdef DMEM_FWD_EN
    chkw("ld_lat", 64'(r_lat), 64'd1);
    chkw("ld_ren_cycles", 64'(r_ren), 64'd0);
`else
    chkw("ld_lat", 64'(r_lat), 64'd2);
    chkw("ld_ren_cycles", 64'(r_ren), 64'd1);
`endif

    issue(1'b1, 1'b0, 64'd1024, 64'h0, 1);
    chkw("oor_lat", 64'(r_lat), 64'd1);
    chk1("oor_err", got_err, 1'b1);
    chkw("oor_data", got_data, 64'h0);
    chkw("oor_strobes", 64'(r_ren + r_wen), 64'd0);

    issue(1'b1, 1'b1, 64'd3, 64'h1234, 1);
    chkw("ill_lat", 64'(r_lat), 64'd1);
    chk1("ill_err", got_err, 1'b1);
    chkw("ill_strobes", 64'(r_ren + r_wen), 64'd0);
    chkw("ill_stall_cycles", 64'(r_stall), 64'd1);

    issue(1'b1, 1'b0, 64'd10, 64'h0, 1);
    chk1("derr_err", got_err, 1'b1);
    chkw("derr_data", got_data, 64'h0);

    issue(1'b1, 1'b0, 64'd6, 64'h0, 0);
    a1 = t_a;
    issue(1'b1, 1'b0, 64'd7, 64'h0, 0);
    chkw("b2b_spacing", 64'(t_a - a1), 64'(ACC + 2));

    for (int k = 0; k < 300; k++) begin
      int op, as;
      logic rd, wr;
      logic [63:0] ad;
      op = $urandom_range(0, 9);
      rd = (op <= 3) || (op == 8);
      wr = (op >= 4 && op <= 8);
      as = $urandom_range(0, 9);
      if (as <= 5) ad = 64'($urandom_range(0, 15));
      else if (as == 6) ad = 64'd1023;
      else if (as == 7) ad = 64'd1024;
      else if (as == 8) ad = {$urandom, $urandom};
      else ad = 64'($urandom_range(0, 1023));
      issue(rd, wr, ad, {$urandom, $urandom},
            $urandom_range(0, 2));
    end

    @(negedge clk);
    #1;
    u3_watch = 1'b1;
    rq3.req_valid = 1'b1;
    rq3.req_rd = 1'b1;
    rq3.req_addr = 64'd9;
    chk1("u3_ready", rq3.req_ready, 1'b1);
    @(posedge clk);
    #1;
    rq3.req_valid = 1'b0;
    chk1("u3_ren_c1", bu3.dm_rEn, 1'b1);
    @(posedge clk);
    #1;
    chk1("u3_ren_c2", bu3.dm_rEn, 1'b1);
    #1;
    rst3 = 1'b1;
    #1;
    chk1("u3_ren_drop", bu3.dm_rEn, 1'b0);
    chk1("u3_rv_rst", rq3.resp_valid, 1'b0);
    @(negedge clk);
    #1;
    rst3 = 1'b0;
    @(posedge clk);
    #1;
    chk1("u3_ready_after", rq3.req_ready, 1'b1);
    repeat (6) @(negedge clk);
    chk1("u3_no_resp", u3_pulse, 1'b0);
    chk1("u3_ren_idle", bu3.dm_rEn, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
